msrv32_instr_encoder: RTL
=========================

Name: msrv32_instr_encoder

Overview:
- Streaming instruction packer: takes decoded instruction fields, an immediate value and an immediate type, and emits the 32-bit RV32I instruction word. Performs the inverse of the core's immediate generator.
- Sits in the debug/self-test path. It builds instruction words for the boot-ROM patcher and feeds the decode-path loopback checker.
- 2-stage valid/ready pipeline with immediate range checking and a saturating error counter.

Parameters:
- ERR_CNT_W, 16, width of saturating error counter
- CHECK_EN, 1, 1 = range/alignment checks active; 0 = err always 0

Ports:
- ms_riscv32_mp_clk_in  input  1  clock
- ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low
- in_valid_in  input  1  request valid
- in_ready_out  output  1  encoder can accept
- imm_type_in  input  3  001 I, 010 S, 011 B, 100 U, 101 J, 110 CSR-zimm; others treated as I
- imm_in  input  32  immediate value (byte offset for B/J, full value for U)
- opcode_in  input  7  instr[6:0]
- rd_in  input  5  rd field
- funct3_in  input  3  funct3 field
- rs1_in  input  5  rs1 field
- rs2_in  input  5  rs2 field
- funct7_in  input  7  funct7 field; for CSR type, {funct7,rs2} is the CSR address
- out_valid_out  output  1  instruction valid
- out_ready_in  input  1  consumer accepts
- instr_out  output  32  encoded instruction
- err_out  output  1  immediate not representable for this type (qualified by out_valid_out)
- err_count_out  output  ERR_CNT_W  saturating count of err transfers

Behaviour:
- Clock and reset: one clock, ms_riscv32_mp_clk_in. Reset ms_riscv32_mp_rst_n_in is asynchronous and active-low.
- Reset values: both stage valids 0, out_valid_out 0, instr_out 0, err_out 0, err_count_out 0.
- Reset asserted mid-operation drops all in-flight items. in_ready_out is 1 in the first cycle after release.
- Input acceptance: transfer when in_valid_in && in_ready_out.
- Stage 1 (S1) registers the packed word and error flag.
- Stage 2 (S2) is the output register.
- Latency: accepted in cycle N, appears on out_valid_out in cycle N+2 if not stalled.
- Advance rules:
  - s2_adv = !s2_valid || out_ready_in
  - s1_adv = s1_valid && s2_adv
  - in_ready_out = !s1_valid || s2_adv (combinational through out_ready_in)
- Throughput is 1 per cycle with out_ready_in held high.
- Handshake rules:
  - out_valid_out, instr_out and err_out hold stable while out_valid_out && !out_ready_in.
  - Order is preserved; no drops or duplicates.
  - At most 2 items are held.
- Packing, by type; fields not listed come from the field inputs:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - CSR: [31:20]={funct7,rs2}, [19:15]=imm[4:0].
  - opcode is always [6:0].
- Error conditions (computed in S1, only when CHECK_EN=1):
  - I/S: imm[31:11] not all-equal.
  - B: imm[31:12] not all-equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - J: imm[31:20] not all-equal, or imm[0]=1.
  - CSR: imm[31:5]!=0.
  - Types 000/111 encode as I, with err computed as for I.
- On error the word is still packed with truncation. Only err_out flags it.
- Round-trip invariant: when err=0, passing instr_out[31:7] and the type (with 000/111 replaced by 001) through the immediate generator returns imm_in exactly.
- err_count_out increments on each output transfer with err_out=1 and saturates at all-ones.

Decomposition:
- Shared package msrv32_pkg holds:
  - immediate type constants (IMM_I=3'b001 … IMM_CSR=3'b110)
  - a fields struct {opcode, rd, funct3, rs1, rs2, funct7}
- One combinational sub-module, msrv32_imm_packer: packing plus range check, instantiated in S1. The top holds the pipeline and counter.

Test Plan:
- I-type: imm=0xFFFFFFFF, opcode=0x13, rd=1, f3=0, rs1=2 -> instr_out=0xFFF10093, err=0, appears exactly 2 cycles after accept.
- S-type: imm=8, opcode=0x23, f3=2, rs1=2, rs2=5 -> 0x00512423, err=0.
- U and J types:
  - U: imm=0x12345000, opcode=0x37, rd=10 -> 0x12345537.
  - J: imm=0x800, opcode=0x6F, rd=1 -> 0x001000EF.
- Errors: B-type imm=3 -> err_out=1, err_count_out=1. CSR-type imm=0x20 -> err_out=1, err_count_out=2. Preload counter to max-1, send 3 errors -> holds at all-ones.
- Backpressure: out_ready_in=0 for 4 cycles while 3 valid requests are offered.
  - After 2 accepts, in_ready_out=0.
  - The output stays frozen on item 1.
  - On release all 3 emerge in order, back-to-back.
- Reset mid-flight: 2 items in pipe, pulse ms_riscv32_mp_rst_n_in low asynchronously (between edges) -> out_valid_out drops immediately, no stale item after release. Random fields with err=0 pass the round-trip check against the immediate generator for 10k vectors.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared types for the instruction encoder: immediate type codes and the
// non-immediate instruction fields.
package msrv32_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IMM_T_W  = 3;

  localparam logic [IMM_T_W-1:0] IMM_I   = 3'b001;
  localparam logic [IMM_T_W-1:0] IMM_S   = 3'b010;
  localparam logic [IMM_T_W-1:0] IMM_B   = 3'b011;
  localparam logic [IMM_T_W-1:0] IMM_U   = 3'b100;
  localparam logic [IMM_T_W-1:0] IMM_J   = 3'b101;
  localparam logic [IMM_T_W-1:0] IMM_CSR = 3'b110;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
  } fields_t;

  // True when v[31:lsb] are all the same bit, i.e. v fits a signed field ending at lsb.
  function automatic logic sext_ok(input logic [XLEN-1:0] v, input int unsigned lsb);
    logic signed [XLEN-1:0] t;
    t = $signed(v) >>> lsb;
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/msrv32_instr_encoder_if.sv
// Request/response bus of the instruction encoder.
interface msrv32_instr_encoder_if;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [2:0]  imm_type_in;
  logic [31:0] imm_in;
  logic [6:0]  opcode_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rs1_in;
  logic [4:0]  rs2_in;
  logic [6:0]  funct7_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] instr_out;
  logic        err_out;

  modport master (
    output in_valid_in, imm_type_in, imm_in, opcode_in, rd_in, funct3_in,
           rs1_in, rs2_in, funct7_in, out_ready_in,
    input  in_ready_out, out_valid_out, instr_out, err_out
  );

  modport slave (
    input  in_valid_in, imm_type_in, imm_in, opcode_in, rd_in, funct3_in,
           rs1_in, rs2_in, funct7_in, out_ready_in,
    output in_ready_out, out_valid_out, instr_out, err_out
  );
endinterface

// File: rtl/msrv32_imm_packer.sv
// Combinational RV32I word packer: scatters the immediate per type and flags
// immediates that the chosen format cannot represent.
module msrv32_imm_packer
  import msrv32_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic [IMM_T_W-1:0] imm_type,
  input  logic [XLEN-1:0]    imm,
  input  fields_t            fields,
  output logic [XLEN-1:0]    word_c,
  output logic               err_c
);

  logic err_raw;

  always_comb begin
    word_c  = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
    err_raw = !sext_ok(imm, 11);
    case (imm_type)
      IMM_S: begin
        word_c  = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        err_raw = !sext_ok(imm, 11);
      end
      IMM_B: begin
        word_c  = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                   imm[4:1], imm[11], fields.opcode};
        err_raw = !sext_ok(imm, 12) || imm[0];
      end
      IMM_U: begin
        word_c  = {imm[31:12], fields.rd, fields.opcode};
        err_raw = |imm[11:0];
      end
      IMM_J: begin
        word_c  = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        err_raw = !sext_ok(imm, 20) || imm[0];
      end
      IMM_CSR: begin
        word_c  = {fields.funct7, fields.rs2, imm[4:0], fields.funct3, fields.rd, fields.opcode};
        err_raw = |imm[31:5];
      end
      default: ;
    endcase
    err_c = CHECK_EN && err_raw;
  end

endmodule

// File: rtl/msrv32_instr_encoder.sv
// Two-stage valid/ready instruction encoder with a saturating count of
// unrepresentable-immediate transfers.
module msrv32_instr_encoder
  import msrv32_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16,
  parameter bit          CHECK_EN  = 1'b1
) (
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_n_in,
  msrv32_instr_encoder_if.slave bus,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  fields_t          fields;
  logic [XLEN-1:0]  pack_word;
  logic             pack_err;
  logic             s1_valid;
  logic [XLEN-1:0]  s1_word;
  logic             s1_err;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_ready;
  logic             in_fire;
  logic             err_fire;

  assign fields = '{opcode: bus.opcode_in, rd: bus.rd_in, funct3: bus.funct3_in,
                    rs1: bus.rs1_in, rs2: bus.rs2_in, funct7: bus.funct7_in};

  msrv32_imm_packer #(.CHECK_EN(CHECK_EN)) u_packer (
    .imm_type (bus.imm_type_in),
    .imm      (bus.imm_in),
    .fields   (fields),
    .word_c   (pack_word),
    .err_c    (pack_err)
  );

  // Ready is combinational through out_ready_in so a full pipe still streams.
  assign s2_adv           = !bus.out_valid_out || bus.out_ready_in;
  assign s1_adv           = s1_valid && s2_adv;
  assign in_ready         = !s1_valid || s2_adv;
  assign in_fire          = bus.in_valid_in && in_ready;
  assign err_fire         = bus.out_valid_out && bus.out_ready_in && bus.err_out;
  assign bus.in_ready_out = in_ready;

  // Stage 1: packed word and error flag.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_err   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid_in;
      if (in_fire) begin
        s1_word <= pack_word;
        s1_err  <= pack_err;
      end
    end
  end

  // Stage 2: output register and error counter.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      bus.out_valid_out <= 1'b0;
      bus.instr_out     <= '0;
      bus.err_out       <= 1'b0;
      err_count_out     <= '0;
    end else begin
      if (s2_adv) begin
        bus.out_valid_out <= s1_valid;
        if (s1_adv) begin
          bus.instr_out <= s1_word;
          bus.err_out   <= s1_err;
        end
      end
      if (err_fire && (err_count_out != '1)) begin
        err_count_out <= err_count_out + ERR_CNT_W'(1);
      end
    end
  end

endmodule
